alu_exec_ctrl: RTL and testbench

Sequential execute controller for the 8-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8×8-bit register file. It drives the ALU's A/B/OP inputs, captures the ALU's Result/Zero/Carry, and writes the result back to the register file. It sits directly upstream and downstream of the ALU, which stays a separate combinational instance wired to the `alu_*` ports.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_exec_ctrl_regfile.sv | 49 ++++
 rtl/alu_exec_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its execute controller:
// opcode constants, datapath width and controller state encoding.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_EQ  = 4'd5;
    localparam logic [3:0] OP_GT  = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// Register file for the execute controller: two operand read ports, one debug
// read port, one synchronous write port; register 0 is hard-wired to zero.
module alu_regfile #(
    parameter int NREG   = 8,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    // Next-state of the storage array; writes to register 0 are dropped.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != {AW{1'b0}})) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d[0] = {DATA_W{1'b0}};
        end
    end

    // Storage array with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ra_data  = (ra_addr  == {AW{1'b0}}) ? {DATA_W{1'b0}} : mem_q[ra_addr];
    assign rb_data  = (rb_addr  == {AW{1'b0}}) ? {DATA_W{1'b0}} : mem_q[rb_addr];
    assign dbg_data = (dbg_addr == {AW{1'b0}}) ? {DATA_W{1'b0}} : mem_q[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequential execute controller: accepts one instruction, drives the external
// combinational ALU for one cycle, then writes the result back (IDLE->EXEC->WB).
module alu_exec_ctrl #(
    parameter int NREG   = 8,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              out_valid,
    output logic [AW-1:0]     out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    import alu_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [AW-1:0]     out_rd_q, out_rd_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] rs_data_s, rt_data_s;

    alu_regfile #(
        .NREG   (NREG),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (in_rs),
        .ra_data  (rs_data_s),
        .rb_addr  (in_rt),
        .rb_data  (rt_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (state_q == WB),
        .waddr    (out_rd_q),
        .wdata    (out_data_q)
    );

    // Next-state and output-register logic for the three-state sequence.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_op_d = in_op;
                    alu_a_d  = rs_data_s;
                    alu_b_d  = in_use_imm ? in_imm : rt_data_s;
                    out_rd_d = in_rd;
                    state_d  = EXEC;
                end else begin
                    state_d  = IDLE;
                end
            end
            EXEC: begin
                out_data_d = alu_result;
                flag_z_d   = alu_zero;
                flag_c_d   = alu_carry;
                state_d    = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The strobe flop leads the state by one decision so it is high exactly in WB.
        out_valid_d = (state_d == WB);
    end

    // Controller state and registered outputs with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= {DATA_W{1'b0}};
            alu_b_q     <= {DATA_W{1'b0}};
            alu_op_q    <= 4'd0;
            out_rd_q    <= {AW{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 8-bit ALU wired to the
// alu_* ports; expected values are hand-computed constants.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [2:0] in_rd, in_rs, in_rt;
    logic [7:0] in_imm;
    logic       in_use_imm;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry;
    logic       out_valid;
    logic [2:0] out_rd;
    logic [7:0] out_data;
    logic       flag_z, flag_c;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_ctrl #(.NREG(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_rd     (out_rd),
        .out_data   (out_data),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: bit 8 of the 9-bit result is the carry/borrow.
    logic [8:0] res9;
    always_comb begin
        res9 = 9'd0;
        case (alu_op)
            4'd0: res9 = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: res9 = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2: res9 = {1'b0, alu_a & alu_b};
            4'd3: res9 = {1'b0, alu_a | alu_b};
            4'd4: res9 = {1'b0, alu_a ^ alu_b};
            4'd5: res9 = {8'd0, (alu_a == alu_b)};
            4'd6: res9 = {8'd0, (alu_a > alu_b)};
            4'd7: res9 = {alu_a, 1'b0};
            4'd8: res9 = {1'b0, 1'b0, alu_a[7:1]};
            4'd9: res9 = {1'b0, alu_a * alu_b};
            default: res9 = 9'd0;
        endcase
    end
    assign alu_result = res9[7:0];
    assign alu_zero   = (res9[7:0] == 8'd0);
    assign alu_carry  = res9[8];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm, input logic use_imm);
        in_op      = op;
        in_rd      = rd;
        in_rs      = rs;
        in_rt      = rt;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_valid   = 1'b1;
    endtask

    // Issue one instruction (called just after a falling edge in IDLE) and check every phase.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [2:0] rd,
                             input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm,
                             input logic use_imm, input logic [7:0] exp_a, input logic [7:0] exp_b,
                             input logic [7:0] exp_d, input logic exp_z, input logic exp_c);
        chk1({tag, "_ready_idle"}, in_ready, 1'b1);
        drive(op, rd, rs, rt, imm, use_imm);
        @(negedge clk);
        in_valid = 1'b0;
        chk1({tag, "_ready_exec"}, in_ready, 1'b0);
        chk1({tag, "_valid_exec"}, out_valid, 1'b0);
        chk({tag, "_alu_a"}, alu_a, exp_a);
        chk({tag, "_alu_b"}, alu_b, exp_b);
        chk({tag, "_alu_op"}, {4'd0, alu_op}, {4'd0, op});
        @(negedge clk);
        chk1({tag, "_valid_wb"}, out_valid, 1'b1);
        chk1({tag, "_ready_wb"}, in_ready, 1'b0);
        chk({tag, "_out_rd"}, {5'd0, out_rd}, {5'd0, rd});
        chk({tag, "_out_data"}, out_data, exp_d);
        chk1({tag, "_flag_z"}, flag_z, exp_z);
        chk1({tag, "_flag_c"}, flag_c, exp_c);
        @(negedge clk);
        chk1({tag, "_valid_drop"}, out_valid, 1'b0);
        chk({tag, "_data_hold"}, out_data, exp_d);
        dbg_addr = rd;
        #1;
        chk({tag, "_dbg"}, dbg_data, (rd == 3'd0) ? 8'h00 : exp_d);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 4'd0;
        in_rd      = 3'd0;
        in_rs      = 3'd0;
        in_rt      = 3'd0;
        in_imm     = 8'h00;
        in_use_imm = 1'b0;
        dbg_addr   = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_ready", in_ready, 1'b1);
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk1("rst_flag_z", flag_z, 1'b0);
        chk1("rst_flag_c", flag_c, 1'b0);
        rst = 1'b0;

        run_instr("add_imm5", 4'd0, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0);
        run_instr("ld_r1",    4'd0, 3'd1, 3'd0, 3'd0, 8'hF0, 1'b1, 8'h00, 8'hF0, 8'hF0, 1'b0, 1'b0);
        run_instr("ld_r2",    4'd0, 3'd2, 3'd0, 3'd0, 8'h20, 1'b1, 8'h00, 8'h20, 8'h20, 1'b0, 1'b0);
        run_instr("add_c",    4'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1);
        run_instr("sub_z",    4'd1, 3'd4, 3'd1, 3'd1, 8'h00, 1'b0, 8'hF0, 8'hF0, 8'h00, 1'b1, 1'b0);
        run_instr("ld_r5",    4'd0, 3'd5, 3'd0, 3'd0, 8'h01, 1'b1, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
        run_instr("sub_brw",  4'd1, 3'd6, 3'd5, 3'd0, 8'h02, 1'b1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1);
        run_instr("wr_r0",    4'd0, 3'd0, 3'd0, 3'd0, 8'h07, 1'b1, 8'h00, 8'h07, 8'h07, 1'b0, 1'b0);
        dbg_addr = 3'd3;
        #1;
        chk("dbg_r3", dbg_data, 8'h10);

        // Back-to-back with in_valid held: accepts at E0 and E3, second reads the first's result.
        drive(4'd0, 3'd1, 3'd0, 3'd0, 8'h03, 1'b1);
        @(negedge clk);
        drive(4'd7, 3'd2, 3'd1, 3'd0, 8'h00, 1'b1);
        chk1("b2b_ready_e0", in_ready, 1'b0);
        @(negedge clk);
        chk1("b2b_ready_e1", in_ready, 1'b0);
        chk1("b2b_valid_e1", out_valid, 1'b1);
        chk("b2b_data1", out_data, 8'h03);
        @(negedge clk);
        chk1("b2b_ready_e2", in_ready, 1'b1);
        chk1("b2b_valid_e2", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk1("b2b_ready_e3", in_ready, 1'b0);
        chk("b2b_raw_a", alu_a, 8'h03);
        chk("b2b_op", {4'd0, alu_op}, 8'h07);
        @(negedge clk);
        chk1("b2b_valid_e4", out_valid, 1'b1);
        chk("b2b_data2", out_data, 8'h06);
        @(negedge clk);
        dbg_addr = 3'd2;
        #1;
        chk("b2b_dbg_r2", dbg_data, 8'h06);

        // Leave non-zero state behind, then abort an instruction in EXEC.
        run_instr("sub_pre",  4'd1, 3'd6, 3'd0, 3'd0, 8'h01, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
        drive(4'd0, 3'd7, 3'd0, 3'd0, 8'h09, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk1("abort_in_exec", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk1("abort_ready", in_ready, 1'b1);
        chk1("abort_valid", out_valid, 1'b0);
        chk1("abort_flag_z", flag_z, 1'b0);
        chk1("abort_flag_c", flag_c, 1'b0);
        chk("abort_out_data", out_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("abort_no_pulse", out_valid, 1'b0);
        end
        dbg_addr = 3'd7;
        #1;
        chk("abort_dbg_r7", dbg_data, 8'h00);
        dbg_addr = 3'd3;
        #1;
        chk("abort_dbg_r3", dbg_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
